// File: rtl/sat_updown_db.sv
// Debounced up/down counter with two raw active-low buttons, optional saturation
// at 0 and 2^WIDTH-1, and a one-cycle pulse whenever a press is clamped.
module sat_updown_db #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 4,
  parameter int STEP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_inc_n,
  input  logic             btn_dec_n,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             sat_hit
);

  localparam int              CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [WIDTH:0]  STEP_X  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  // Bit 0 is the increment button, bit 1 the decrement button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_d;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] count_nxt;
  logic             sat_nxt;

  assign raw = {btn_dec_n, btn_inc_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The new level is accepted on the DEBOUNCE-th consecutive differing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= '1;
      db_d   <= '1;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db_d & ~db;

  // Carry/borrow out of the WIDTH+1 bit sum/difference is the exact limit test.
  always_comb begin
    sum       = {1'b0, count} + STEP_X;
    diff      = {1'b0, count} - STEP_X;
    count_nxt = count;
    sat_nxt   = 1'b0;
    case (press)
      2'b01: begin
        if (!wrap_en && sum[WIDTH]) begin
          count_nxt = MAX_V;
          sat_nxt   = 1'b1;
        end else begin
          count_nxt = sum[WIDTH-1:0];
        end
      end
      2'b10: begin
        if (!wrap_en && diff[WIDTH]) begin
          count_nxt = '0;
          sat_nxt   = 1'b1;
        end else begin
          count_nxt = diff[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      at_max  <= 1'b0;
      at_min  <= 1'b1;
      sat_hit <= 1'b0;
    end else begin
      count   <= count_nxt;
      at_max  <= (count_nxt == MAX_V);
      at_min  <= (count_nxt == '0);
      sat_hit <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_sat_updown_db.sv
// Directed self-checking bench for sat_updown_db: a 2-bit/step-1 instance and a
// 4-bit/step-5 instance, both with DEBOUNCE=4.
module tb_sat_updown_db;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc_a = 1'b1, dec_a = 1'b1, wrap_a = 1'b0;
  logic       inc_b = 1'b1, dec_b = 1'b1, wrap_b = 1'b0;
  logic [1:0] count_a;
  logic [3:0] count_b;
  logic       at_max_a, at_min_a, sat_a;
  logic       at_max_b, at_min_b, sat_b;

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clk = ~clk;

  sat_updown_db #(.WIDTH(2), .DEBOUNCE(4), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_inc_n(inc_a), .btn_dec_n(dec_a),
    .wrap_en(wrap_a), .count(count_a), .at_max(at_max_a), .at_min(at_min_a),
    .sat_hit(sat_a)
  );

  sat_updown_db #(.WIDTH(4), .DEBOUNCE(4), .STEP(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_inc_n(inc_b), .btn_dec_n(dec_b),
    .wrap_en(wrap_b), .count(count_b), .at_max(at_max_b), .at_min(at_min_b),
    .sat_hit(sat_b)
  );

  function automatic logic [15:0] cur_count(input int dut);
    return (dut == 0) ? 16'(count_a) : 16'(count_b);
  endfunction

  function automatic logic [15:0] cur_sat(input int dut);
    return (dut == 0) ? 16'(sat_a) : 16'(sat_b);
  endfunction

  function automatic logic [15:0] cur_max(input int dut);
    return (dut == 0) ? 16'(at_max_a) : 16'(at_max_b);
  endfunction

  function automatic logic [15:0] cur_min(input int dut);
    return (dut == 0) ? 16'(at_min_a) : 16'(at_min_b);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int dut, input logic inc_n, input logic dec_n);
    if (dut == 0) begin
      inc_a = inc_n;
      dec_a = dec_n;
    end else begin
      inc_b = inc_n;
      dec_b = dec_n;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press (and later release) the selected button(s) and check the update edge.
  task automatic doPress(input int dut, input bit use_inc, input bit use_dec,
                         input logic [15:0] prev, input logic [15:0] exp_cnt,
                         input logic [15:0] exp_sat, input string tag);
    logic [15:0] max_v;
    max_v = (dut == 0) ? 16'd3 : 16'd15;
    applyStimulus(dut, !use_inc, !use_dec);
    cycles(6);
    checkOutput({tag, "_pre"}, cur_count(dut), prev);
    cycles(1);
    checkOutput({tag, "_count"}, cur_count(dut), exp_cnt);
    checkOutput({tag, "_sat"}, cur_sat(dut), exp_sat);
    checkOutput({tag, "_atmax"}, cur_max(dut), 16'(exp_cnt == max_v));
    checkOutput({tag, "_atmin"}, cur_min(dut), 16'(exp_cnt == 16'd0));
    applyStimulus(dut, 1'b1, 1'b1);
    cycles(10);
    checkOutput({tag, "_hold"}, cur_count(dut), exp_cnt);
    checkOutput({tag, "_satlow"}, cur_sat(dut), 16'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cycles(2);
    checkOutput("rst_count_a", cur_count(0), 16'd0);
    checkOutput("rst_atmin_a", cur_min(0), 16'd1);
    checkOutput("rst_atmax_a", cur_max(0), 16'd0);
    checkOutput("rst_sat_a", cur_sat(0), 16'd0);
    checkOutput("rst_count_b", cur_count(1), 16'd0);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    cycles(1);
    doReset();

    // Held increment: one step on edge 7, nothing more
    applyStimulus(0, 1'b0, 1'b1);
    cycles(6);
    checkOutput("held_pre", cur_count(0), 16'd0);
    cycles(1);
    checkOutput("held_edge7", cur_count(0), 16'd1);
    checkOutput("held_sat", cur_sat(0), 16'd0);
    cycles(13);
    checkOutput("held_end", cur_count(0), 16'd1);
    checkOutput("held_end_sat", cur_sat(0), 16'd0);
    applyStimulus(0, 1'b1, 1'b1);
    cycles(10);

    // Five clean presses with saturation
    doReset();
    doPress(0, 1, 0, 16'd0, 16'd1, 16'd0, "inc1");
    doPress(0, 1, 0, 16'd1, 16'd2, 16'd0, "inc2");
    doPress(0, 1, 0, 16'd2, 16'd3, 16'd0, "inc3");
    doPress(0, 1, 0, 16'd3, 16'd3, 16'd1, "inc4");
    doPress(0, 1, 0, 16'd3, 16'd3, 16'd1, "inc5");

    // Wrap mode; toggling wrap_en alone must not move count
    wrap_a = 1'b1;
    cycles(3);
    checkOutput("wrap_toggle", cur_count(0), 16'd3);
    doPress(0, 1, 0, 16'd3, 16'd0, 16'd0, "wrap_inc");
    doPress(0, 0, 1, 16'd0, 16'd3, 16'd0, "wrap_dec");

    // Three-cycle glitch is filtered
    seen = 1'b0;
    applyStimulus(0, 1'b1, 1'b0);
    cycles(3);
    applyStimulus(0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      seen = seen | sat_a;
    end
    checkOutput("glitch_count", cur_count(0), 16'd3);
    checkOutput("glitch_sat", 16'(seen), 16'd0);

    // Simultaneous presses cancel
    wrap_a = 1'b0;
    doPress(0, 1, 1, 16'd3, 16'd3, 16'd0, "both");

    // Wide instance: reach 12 by wrapping decrements, then overflow clamps
    wrap_b = 1'b1;
    doPress(1, 0, 1, 16'd0, 16'd11, 16'd0, "b_dec1");
    doPress(1, 0, 1, 16'd11, 16'd6, 16'd0, "b_dec2");
    doPress(1, 0, 1, 16'd6, 16'd1, 16'd0, "b_dec3");
    doPress(1, 0, 1, 16'd1, 16'd12, 16'd0, "b_dec4");
    wrap_b = 1'b0;
    doPress(1, 1, 0, 16'd12, 16'd15, 16'd1, "b_inc_clamp");
    doPress(1, 1, 0, 16'd15, 16'd15, 16'd1, "b_inc_atmax");

    // Reset mid-debounce discards the pending press
    applyStimulus(1, 1'b0, 1'b1);
    cycles(3);
    rst_n = 1'b0;
    applyStimulus(1, 1'b1, 1'b1);
    cycles(1);
    checkOutput("midrst_count", cur_count(1), 16'd0);
    checkOutput("midrst_atmin", cur_min(1), 16'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      seen = seen | sat_b | (count_b != 4'd0);
    end
    checkOutput("midrst_noevent", 16'(seen), 16'd0);
    checkOutput("midrst_final", cur_count(1), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sat_updown_db.md
SAT_UPDOWN_DB -- requirements
Module: sat_updown_db

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits, legal range 1..16.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4: consecutive stable cycles required to accept a button level change, legal range 1..255.
REQ-003 The block SHALL have parameter STEP, default 1: increment/decrement magnitude, legal range 1..2^WIDTH-1.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_inc_n  in  1  raw increment button, active-low, asynchronous to clk
- btn_dec_n  in  1  raw decrement button, active-low, asynchronous to clk
- wrap_en  in  1  0 = saturate at limits, 1 = modulo-2^WIDTH wrap
- count  out  WIDTH  current counter value, registered
- at_max  out  1  count == 2^WIDTH-1, registered
- at_min  out  1  count == 0, registered
- sat_hit  out  1  one-cycle pulse: a press was clamped at a limit

Function
REQ-006 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-007 Each button SHALL have an independent debouncer: a counter that increments on every cycle where the synchronised level differs from the debounced level and clears whenever they match.
REQ-008 The debounced level SHALL take the synchronised value on the edge where the differing condition has held for DEBOUNCE consecutive cycles; the debounce counter SHALL clear on that edge.
REQ-009 The debouncer counter width SHALL be the minimum needed to hold DEBOUNCE, with no overflow for any legal DEBOUNCE.
REQ-010 A press event SHALL be a one-cycle pulse generated only on the debounced released->pressed (1->0) transition; release events and held buttons SHALL generate nothing further.
REQ-011 With a stable input, count SHALL update on the (DEBOUNCE+3)th rising edge after the first edge that samples the new raw level: 2 synchroniser edges, DEBOUNCE debounce edges, 1 update edge.
REQ-012 Increment press alone: if wrap_en=0 and count+STEP > 2^WIDTH-1, count SHALL become 2^WIDTH-1 and sat_hit SHALL pulse; otherwise count SHALL become count+STEP mod 2^WIDTH.
REQ-013 Decrement press alone: if wrap_en=0 and count < STEP, count SHALL become 0 and sat_hit SHALL pulse; otherwise count SHALL become count-STEP mod 2^WIDTH.
REQ-014 A press arriving when count is already at the limit with wrap_en=0 SHALL leave count unchanged and SHALL still pulse sat_hit.
REQ-015 Increment and decrement press events in the same cycle SHALL cancel: count unchanged, sat_hit low.
REQ-016 The limit arithmetic SHALL be evaluated at WIDTH+1 bits so that the overflow test is exact.
REQ-017 With wrap_en=1, sat_hit SHALL never assert.
REQ-018 wrap_en SHALL be sampled only on the update edge; changing it SHALL never alter count by itself.
REQ-019 at_max and at_min SHALL be registered and SHALL be consistent with count in the same cycle; with WIDTH=1 they are mutually exclusive, never both high.
REQ-020 sat_hit SHALL be high for exactly one cycle per clamped press, aligned with the count update edge.

Reset
REQ-021 While rst_n=0: count=0, at_min=1, at_max=0, sat_hit=0, synchroniser flops=1, debounced levels=1 (released), debounce counters=0.
REQ-022 A button held pressed through reset deassertion SHALL produce exactly one press event, DEBOUNCE+3 edges after release of reset.
REQ-023 A reset asserted mid-debounce SHALL discard the pending transition; no press event SHALL result from pre-reset activity.

Verification
REQ-024 Bench SHALL cover these scenarios with WIDTH=2, DEBOUNCE=4, STEP=1 unless stated:
- Reset, then btn_inc_n low for 20 cycles -> count 0->1 on edge 7 after the first low sample, then no further change, sat_hit 0.
- 5 clean inc presses, wrap_en=0 -> count 1,2,3,3,3; at_max high from count=3; sat_hit pulses on presses 4 and 5.
- wrap_en=1, count=3, one inc press -> count=0, at_min=1, sat_hit 0; one dec press -> count=3.
- Glitch: btn_dec_n low for 3 cycles, then high -> no press event, count unchanged.
- Both buttons driven low on the same cycle, stable -> count unchanged, sat_hit 0.
- WIDTH=4, STEP=5, count=12, wrap_en=0, inc press -> count=15, sat_hit pulse; rst_n pulsed low mid-debounce -> count=0, no press event.
